// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor controller:
// FSM state encoding and the default operand width.
package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // 2'd3 is unused; the FSM treats it as illegal and returns to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_sub_bit.sv
// One-bit full subtractor cell: d = x - y - bi, with borrow-out bo.
module full_sub_bit (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  // Difference bit and borrow-out of a single bit position.
  always_comb begin
    d  = x ^ y ^ bi;
    bo = (~x & y) | (~(x ^ y) & bi);
  end

endmodule

// File: rtl/serial_subtract_ctrl.sv
// Bit-serial subtractor controller: runs one full_sub_bit cell over WIDTH
// cycles to compute diff = a - b - bin, LSB first, with a registered borrow.
// Optional feature: define SERIAL_SUB_OVF_EN to add the signed overflow
// output ovf (registered with bout when the last bit is processed).
module serial_subtract_ctrl
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             brw;
  logic             d_bit;
  logic             bo_bit;

  full_sub_bit u_cell (
    .x  (a_sh[0]),
    .y  (b_sh[0]),
    .bi (brw),
    .d  (d_bit),
    .bo (bo_bit)
  );

  // Controller FSM: operand capture, serial shift datapath and handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      a_sh  <= '0;
      b_sh  <= '0;
      brw   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            brw   <= bin;
            cnt   <= '0;
            diff  <= '0;
            bout  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf   <= 1'b0;
`endif
            busy  <= 1'b1;
            state <= ST_SHIFT;
          end else begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          a_sh <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh <= {1'b0, b_sh[WIDTH-1:1]};
          diff <= {d_bit, diff[WIDTH-1:1]};
          brw  <= bo_bit;
          busy <= 1'b1;
          if (cnt == CNT_LAST) begin
            // Last bit: a_sh[0]/b_sh[0] are the operand sign bits here.
            cnt   <= '0;
            bout  <= bo_bit;
`ifdef SERIAL_SUB_OVF_EN
            ovf   <= (a_sh[0] != b_sh[0]) && (d_bit != a_sh[0]);
`endif
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            cnt   <= cnt + 1'b1;
            done  <= 1'b0;
            state <= ST_SHIFT;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          cnt   <= '0;
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtract_ctrl.sv
// Self-checking bench for serial_subtract_ctrl: WIDTH=8 directed tests plus
// an exhaustive WIDTH=4 sweep. Define SERIAL_SUB_OVF_EN to also check ovf.
module tb_serial_subtract_ctrl;

  logic       clk;
  logic       rst;

  logic       start8;
  logic [7:0] a8, b8;
  logic       bin8;
  logic       busy8, done8, bout8;
  logic [7:0] diff8;

  logic       start4;
  logic [3:0] a4, b4;
  logic       bin4;
  logic       busy4, done4, bout4;
  logic [3:0] diff4;

`ifdef SERIAL_SUB_OVF_EN
  logic       ovf8, ovf4;
`endif

  int checks;
  int failures;

  serial_subtract_ctrl #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .bin   (bin8),
    .busy  (busy8),
    .done  (done8),
    .diff  (diff8),
    .bout  (bout8)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf8)
`endif
  );

  serial_subtract_ctrl #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .rst   (rst),
    .start (start4),
    .a     (a4),
    .b     (b4),
    .bin   (bin4),
    .busy  (busy4),
    .done  (done4),
    .diff  (diff4),
    .bout  (bout4)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf4)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one WIDTH=8 operation; optionally pulse start during SHIFT and DONE.
  // lat = edges after the accept edge until done is seen (0 if never).
  task automatic run_op8(input logic [7:0] av, input logic [7:0] bv, input logic bv_in,
                         input bit junk_starts,
                         output int lat, output int busy_cycles, output int pulses);
    @(negedge clk);
    a8 = av; b8 = bv; bin8 = bv_in; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    a8 = 8'h5A; b8 = 8'hC3; bin8 = 1'b1;
    lat = 0; pulses = 0;
    busy_cycles = busy8 ? 1 : 0;
    for (int i = 1; i <= 14; i++) begin
      @(posedge clk); #1;
      if (done8) begin
        pulses++;
        if (lat == 0) lat = i;
      end
      if (busy8) busy_cycles++;
      if (junk_starts && (i == 3 || i == 8)) start8 = 1'b1;
      else start8 = 1'b0;
    end
    start8 = 1'b0;
  endtask

  task automatic test_reset();
    if (busy8 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy8); end
    checks++;
    if (done8 !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done8); end
    checks++;
    if (diff8 !== 8'h00) begin failures++; $display("FAIL reset_diff got=%h exp=00", diff8); end
    checks++;
    if (bout8 !== 1'b0) begin failures++; $display("FAIL reset_bout got=%b exp=0", bout8); end
    checks++;
  endtask

  task automatic test_basic();
    int lat, bc, p;
    run_op8(8'h05, 8'h03, 1'b0, 1'b0, lat, bc, p);
    if (diff8 !== 8'h02) begin failures++; $display("FAIL basic_diff got=%h exp=02", diff8); end
    checks++;
    if (bout8 !== 1'b0) begin failures++; $display("FAIL basic_bout got=%b exp=0", bout8); end
    checks++;
    if (lat !== 8) begin failures++; $display("FAIL basic_latency got=%0d exp=8", lat); end
    checks++;
    if (bc !== 9) begin failures++; $display("FAIL basic_busy_cycles got=%0d exp=9", bc); end
    checks++;
    if (p !== 1) begin failures++; $display("FAIL basic_done_pulses got=%0d exp=1", p); end
    checks++;
  endtask

  task automatic test_borrow();
    int lat, bc, p;
    run_op8(8'h03, 8'h05, 1'b0, 1'b0, lat, bc, p);
    if (diff8 !== 8'hFE) begin failures++; $display("FAIL borrow_diff got=%h exp=fe", diff8); end
    checks++;
    if (bout8 !== 1'b1) begin failures++; $display("FAIL borrow_bout got=%b exp=1", bout8); end
    checks++;
    run_op8(8'h00, 8'h00, 1'b1, 1'b0, lat, bc, p);
    if (diff8 !== 8'hFF) begin failures++; $display("FAIL bin_diff got=%h exp=ff", diff8); end
    checks++;
    if (bout8 !== 1'b1) begin failures++; $display("FAIL bin_bout got=%b exp=1", bout8); end
    checks++;
  endtask

  task automatic test_busy_start();
    int lat, bc, p;
    run_op8(8'hFF, 8'h00, 1'b0, 1'b1, lat, bc, p);
    if (p !== 1) begin failures++; $display("FAIL ignore_done_pulses got=%0d exp=1", p); end
    checks++;
    if (lat !== 8) begin failures++; $display("FAIL ignore_latency got=%0d exp=8", lat); end
    checks++;
    if (diff8 !== 8'hFF) begin failures++; $display("FAIL ignore_diff got=%h exp=ff", diff8); end
    checks++;
    if (bout8 !== 1'b0) begin failures++; $display("FAIL ignore_bout got=%b exp=0", bout8); end
    checks++;
    run_op8(8'h10, 8'h20, 1'b0, 1'b0, lat, bc, p);
    if (diff8 !== 8'hF0) begin failures++; $display("FAIL restart_diff got=%h exp=f0", diff8); end
    checks++;
    if (bout8 !== 1'b1) begin failures++; $display("FAIL restart_bout got=%b exp=1", bout8); end
    checks++;
  endtask

  task automatic test_mid_reset();
    int lat, bc, p;
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'h00; bin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    if (diff8 !== 8'hE0) begin failures++; $display("FAIL midrst_partial_diff got=%h exp=e0", diff8); end
    checks++;
    rst = 1'b1;
    #1;
    if (busy8 !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy8); end
    checks++;
    if (done8 !== 1'b0) begin failures++; $display("FAIL midrst_done got=%b exp=0", done8); end
    checks++;
    if (diff8 !== 8'h00) begin failures++; $display("FAIL midrst_diff got=%h exp=00", diff8); end
    checks++;
    if (bout8 !== 1'b0) begin failures++; $display("FAIL midrst_bout got=%b exp=0", bout8); end
    checks++;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    p = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done8) p++;
    end
    if (p !== 0) begin failures++; $display("FAIL midrst_no_done got=%0d exp=0", p); end
    checks++;
    run_op8(8'h05, 8'h03, 1'b0, 1'b0, lat, bc, p);
    if (diff8 !== 8'h02) begin failures++; $display("FAIL midrst_next_diff got=%h exp=02", diff8); end
    checks++;
    if (p !== 1) begin failures++; $display("FAIL midrst_next_pulses got=%0d exp=1", p); end
    checks++;
  endtask

`ifdef SERIAL_SUB_OVF_EN
  task automatic test_ovf();
    int lat, bc, p;
    run_op8(8'h80, 8'h01, 1'b0, 1'b0, lat, bc, p);
    if (diff8 !== 8'h7F) begin failures++; $display("FAIL ovf_diff got=%h exp=7f", diff8); end
    checks++;
    if (ovf8 !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", ovf8); end
    checks++;
    run_op8(8'h05, 8'h03, 1'b0, 1'b0, lat, bc, p);
    if (ovf8 !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", ovf8); end
    checks++;
  endtask
`endif

  task automatic test_sweep4();
    logic [4:0] ref_v;
    logic [3:0] av, bv;
    bit         got;
`ifdef SERIAL_SUB_OVF_EN
    logic       ovf_exp;
`endif
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          av = 4'(ia);
          bv = 4'(ib);
          ref_v = 5'(ia - ib - ic);
          @(negedge clk);
          a4 = av; b4 = bv; bin4 = ic[0]; start4 = 1'b1;
          @(posedge clk); #1;
          start4 = 1'b0;
          got = 1'b0;
          for (int k = 0; k < 10 && !got; k++) begin
            @(posedge clk); #1;
            if (done4) got = 1'b1;
          end
          if (!got) begin
            failures++;
            $display("FAIL sweep_timeout a=%h b=%h bin=%0d got=no_done exp=done", av, bv, ic);
          end else if ({bout4, diff4} !== ref_v) begin
            failures++;
            $display("FAIL sweep a=%h b=%h bin=%0d got=%h exp=%h", av, bv, ic, {bout4, diff4}, ref_v);
          end
          checks++;
`ifdef SERIAL_SUB_OVF_EN
          ovf_exp = (av[3] != bv[3]) && (ref_v[3] != av[3]);
          if (ovf4 !== ovf_exp) begin
            failures++;
            $display("FAIL sweep_ovf a=%h b=%h bin=%0d got=%b exp=%b", av, bv, ic, ovf4, ovf_exp);
          end
          checks++;
`endif
          @(posedge clk);
        end
      end
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1;
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; bin8 = 1'b0;
    start4 = 1'b0; a4 = 4'h0; b4 = 4'h0; bin4 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_borrow();
    test_busy_start();
    test_mid_reset();
`ifdef SERIAL_SUB_OVF_EN
    test_ovf();
`endif
    test_sweep4();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
